// File: rtl/edge_regbank_pkg.sv
// Shared types for the edge-detection AXI4-Lite register bank: response codes,
// channel FSM states and the byte-strobe merge helper.
package edge_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Widest supported data bus; narrower buses are zero-extended into the helper.
  localparam int MAX_DW = 64;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} rd_state_t;

  function automatic logic [MAX_DW-1:0] strb_merge(input logic [MAX_DW-1:0]   old_val,
                                                   input logic [MAX_DW-1:0]   wdata,
                                                   input logic [MAX_DW/8-1:0] wstrb);
    logic [MAX_DW-1:0] merged;
    merged = old_val;
    for (int b = 0; b < MAX_DW / 8; b++) begin
      if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/edge_regbank_axil_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the register bank (slave).
interface edge_regbank_axil_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/edge_regbank_wcapture.sv
// Independent AW/W capture: each slot is held until the write response retires.
// A ready is high only while its slot is empty, the bank is idle and out of reset.
module edge_regbank_wcapture #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    enable,
  input  logic                    busy,
  input  logic                    clear,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ADDR_WIDTH-1:0]   cap_addr,
  output logic [DATA_WIDTH-1:0]   cap_data,
  output logic [DATA_WIDTH/8-1:0] cap_strb,
  output logic                    both_held
);
  logic aw_held;
  logic w_held;

  assign awready   = enable & ~busy & ~aw_held;
  assign wready    = enable & ~busy & ~w_held;
  assign both_held = aw_held & w_held;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
      cap_strb <= '0;
    end else begin
      if (clear) begin
        aw_held <= 1'b0;
      end else if (awvalid && awready) begin
        aw_held  <= 1'b1;
        cap_addr <= awaddr;
      end
      if (clear) begin
        w_held <= 1'b0;
      end else if (wvalid && wready) begin
        w_held   <= 1'b1;
        cap_data <= wdata;
        cap_strb <= wstrb;
      end
    end
  end
endmodule

// File: rtl/edge_regbank_axil.sv
// Parametrised AXI4-Lite register bank: write commits one cycle after AW+W are both held,
// reads return one cycle after AR; one outstanding transaction per direction.
module edge_regbank_axil
  import edge_regbank_pkg::*;
#(
  parameter int                     DATA_WIDTH = 32,
  parameter int                     NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]    RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0]  RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  edge_regbank_axil_if.slave             s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_regs,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);
  localparam int LSB        = $clog2(DATA_WIDTH / 8);
  localparam int IDX_WIDTH  = $clog2(NUM_REGS);
  localparam int ADDR_WIDTH = IDX_WIDTH + LSB;

  wr_state_t w_state, w_next;
  rd_state_t r_state, r_next;

  logic                    live;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic [DATA_WIDTH-1:0]   cap_data;
  logic [DATA_WIDTH/8-1:0] cap_strb;
  logic                    both_held;
  logic                    commit;
  logic                    ar_fire;
  logic [IDX_WIDTH-1:0]    w_idx;
  logic [IDX_WIDTH-1:0]    r_idx;
  logic [NUM_REGS-1:0]     w_hit;
  logic                    w_hit_ro;
  logic [DATA_WIDTH-1:0]   r_val;
  logic [1:0]              r_resp_val;
  logic [1:0]              bresp_q;
  logic [1:0]              rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
  logic                    unused_ok;

  // Readies stay low through reset and rise on the first edge after release.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) live <= 1'b0;
    else        live <= 1'b1;
  end

  edge_regbank_wcapture #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wcapture (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .enable    (live),
    .busy      (w_state == W_RESP),
    .clear     ((w_state == W_RESP) && s_axi.bready),
    .awaddr    (s_axi.awaddr),
    .awvalid   (s_axi.awvalid),
    .awready   (s_axi.awready),
    .wdata     (s_axi.wdata),
    .wstrb     (s_axi.wstrb),
    .wvalid    (s_axi.wvalid),
    .wready    (s_axi.wready),
    .cap_addr  (cap_addr),
    .cap_data  (cap_data),
    .cap_strb  (cap_strb),
    .both_held (both_held)
  );

  assign commit = (w_state == W_IDLE) && both_held;
  assign w_idx  = cap_addr[ADDR_WIDTH-1:LSB];
  assign r_idx  = s_axi.araddr[ADDR_WIDTH-1:LSB];

  // Write FSM
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (both_held)    w_next = W_RESP;
      W_RESP:  if (s_axi.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi.bvalid = (w_state == W_RESP);
    s_axi.bresp  = bresp_q;
  end

  // Read-only and out-of-range indices leave w_hit empty, so they never update or pulse.
  always_comb begin
    w_hit    = '0;
    w_hit_ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == IDX_WIDTH'(i)) begin
        if (RO_MASK[i]) w_hit_ro = 1'b1;
        else            w_hit[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      bresp_q      <= RESP_OKAY;
      reg_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      reg_wr_pulse <= commit ? w_hit : '0;
      if (commit) begin
        bresp_q <= w_hit_ro ? RESP_SLVERR : ((|w_hit) ? RESP_OKAY : RESP_DECERR);
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_hit[i]) begin
            regs[i] <= DATA_WIDTH'(strb_merge(MAX_DW'(regs[i]), MAX_DW'(cap_data),
                                              (MAX_DW/8)'(cap_strb)));
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign ctrl_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  // Read FSM
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire)      r_next = R_RESP;
      R_RESP:  if (s_axi.rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.arready = live && (r_state == R_IDLE);
    s_axi.rvalid  = (r_state == R_RESP);
    s_axi.rdata   = rdata_q;
    s_axi.rresp   = rresp_q;
  end

  assign ar_fire = s_axi.arvalid && live && (r_state == R_IDLE);

  always_comb begin
    r_val      = '0;
    r_resp_val = RESP_DECERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_idx == IDX_WIDTH'(i)) begin
        r_resp_val = RESP_OKAY;
        r_val      = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
      end
    end
  end

  // regs is sampled before any same-edge commit lands, so a colliding read sees the old value.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_fire) begin
      rdata_q <= r_val;
      rresp_q <= r_resp_val;
    end
  end

  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, cap_addr[LSB-1:0],
                       s_axi.araddr[LSB-1:0], status_in};
endmodule

// File: tb/tb_edge_regbank_axil.sv
// Bench for edge_regbank_axil: an 8-register bank with a read-only slot 7 and a
// 6-register bank whose upper indices are unmapped, checked against an array model.
module tb_edge_regbank_axil;
  localparam logic [31:0] RST_A = 32'hDEAD_0000;
  localparam logic [31:0] RST_B = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pulse_total = 0;

  logic [4:0]  awaddr, araddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  logic [255:0] ctrl_a, status_a;
  logic [191:0] ctrl_b, status_b;
  logic [7:0]   pulse_a;
  logic [5:0]   pulse_b;

  edge_regbank_axil_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) ifa ();
  edge_regbank_axil_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) ifb ();

  assign ifa.awaddr = awaddr;  assign ifb.awaddr = awaddr;
  assign ifa.awprot = 3'b000;  assign ifb.awprot = 3'b000;
  assign ifa.wdata  = wdata;   assign ifb.wdata  = wdata;
  assign ifa.wstrb  = wstrb;   assign ifb.wstrb  = wstrb;
  assign ifa.araddr = araddr;  assign ifb.araddr = araddr;
  assign ifa.arprot = 3'b000;  assign ifb.arprot = 3'b000;
  assign ifa.awvalid = awvalid & ~sel;  assign ifb.awvalid = awvalid & sel;
  assign ifa.wvalid  = wvalid  & ~sel;  assign ifb.wvalid  = wvalid  & sel;
  assign ifa.bready  = bready  & ~sel;  assign ifb.bready  = bready  & sel;
  assign ifa.arvalid = arvalid & ~sel;  assign ifb.arvalid = arvalid & sel;
  assign ifa.rready  = rready  & ~sel;  assign ifb.rready  = rready  & sel;

  logic        m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;
  assign m_awready = sel ? ifb.awready : ifa.awready;
  assign m_wready  = sel ? ifb.wready  : ifa.wready;
  assign m_bvalid  = sel ? ifb.bvalid  : ifa.bvalid;
  assign m_bresp   = sel ? ifb.bresp   : ifa.bresp;
  assign m_arready = sel ? ifb.arready : ifa.arready;
  assign m_rvalid  = sel ? ifb.rvalid  : ifa.rvalid;
  assign m_rresp   = sel ? ifb.rresp   : ifa.rresp;
  assign m_rdata   = sel ? ifb.rdata   : ifa.rdata;

  edge_regbank_axil #(.DATA_WIDTH(32), .NUM_REGS(8), .RO_MASK(8'h80), .RESET_VAL(RST_A)) dut_a (
    .ACLK(clk), .ARESET(rst), .s_axi(ifa),
    .ctrl_regs(ctrl_a), .status_in(status_a), .reg_wr_pulse(pulse_a));

  edge_regbank_axil #(.DATA_WIDTH(32), .NUM_REGS(6), .RO_MASK(6'h00), .RESET_VAL(RST_B)) dut_b (
    .ACLK(clk), .ARESET(rst), .s_axi(ifb),
    .ctrl_regs(ctrl_b), .status_in(status_b), .reg_wr_pulse(pulse_b));

  always @(negedge clk) pulse_total = pulse_total + $countones(pulse_a) + $countones(pulse_b);

  // Reference model: plain register arrays per bank.
  logic [31:0] mem [2][8];

  function automatic int nregs(input logic s);
    return s ? 6 : 8;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      mem[0][i] = RST_A;
      mem[1][i] = RST_B;
    end
  endfunction

  function automatic void model_write(input logic s, input int idx, input logic [31:0] d,
                                      input logic [3:0] st, output logic [1:0] resp, output int pulses);
    pulses = 0;
    if (idx >= nregs(s)) begin
      resp = 2'b11;
    end else if (!s && idx == 7) begin
      resp = 2'b10;
    end else begin
      for (int b = 0; b < 4; b++) if (st[b]) mem[s][idx][8*b +: 8] = d[8*b +: 8];
      resp = 2'b00;
      pulses = 1;
    end
  endfunction

  function automatic void model_read(input logic s, input int idx, output logic [31:0] d,
                                     output logic [1:0] resp);
    if (idx >= nregs(s)) begin
      d = 32'h0; resp = 2'b11;
    end else if (!s && idx == 7) begin
      d = status_a[idx*32 +: 32]; resp = 2'b00;
    end else begin
      d = mem[s][idx]; resp = 2'b00;
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int pulses);
    int n, k, p0;
    logic fa, fw;
    @(negedge clk);
    p0 = pulse_total;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      fa = awvalid && m_awready;
      fw = wvalid && m_wready;
      @(negedge clk);
      n++;
      if (fa) awvalid = 1'b0;
      if (fw) wvalid = 1'b0;
    end
    check("wr_accept", n < 20, 1);
    k = 0;
    while (!m_bvalid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("wr_latency", k, 1);
    resp = m_bresp;
    @(negedge clk);
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    pulses = pulse_total - p0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
    int n, k;
    logic fa;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (arvalid && n < 20) begin
      fa = arvalid && m_arready;
      @(negedge clk);
      n++;
      if (fa) arvalid = 1'b0;
    end
    check("rd_accept", n < 20, 1);
    k = 0;
    while (!m_rvalid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rd_latency", k, 0);
    d = m_rdata; r = m_rresp;
    @(negedge clk);
    rready = 1'b0; arvalid = 1'b0;
  endtask

  task automatic write_and_check(input string tag, input logic s, input logic [4:0] a,
                                 input logic [31:0] d, input logic [3:0] st);
    logic [1:0] resp, eresp;
    int p, ep;
    sel = s;
    axi_write(a, d, st, resp, p);
    model_write(s, int'(a) / 4, d, st, eresp, ep);
    check({tag, "_bresp"}, resp, eresp);
    check({tag, "_pulses"}, p, ep);
  endtask

  task automatic read_and_check(input string tag, input logic s, input logic [4:0] a);
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    sel = s;
    axi_read(a, d, r);
    model_read(s, int'(a) / 4, ed, er);
    check({tag, "_rdata"}, d, ed);
    check({tag, "_rresp"}, r, er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int p0;

    rst = 1'b1; sel = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 8; i++) status_a[i*32 +: 32] = $urandom;
    status_a[7*32 +: 32] = 32'hCAFE_F00D;
    for (int i = 0; i < 6; i++) status_b[i*32 +: 32] = $urandom;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", ifa.awready, 0);
    check("rst_wready",  ifa.wready,  0);
    check("rst_arready", ifa.arready, 0);
    check("rst_bvalid",  ifa.bvalid,  0);
    check("rst_rvalid",  ifa.rvalid,  0);
    check("rst_rdata",   ifa.rdata,   0);
    check("rst_bresp",   ifa.bresp,   0);
    check("rst_pulse",   pulse_a,     0);
    for (int i = 0; i < 7; i++) check("rst_reg", ctrl_a[i*32 +: 32], RST_A);
    rst = 1'b0;
    #1;
    check("rel_awready_low", ifa.awready, 0);
    @(posedge clk); #1;
    check("rel_awready", ifa.awready, 1);
    check("rel_wready",  ifa.wready,  1);
    check("rel_arready", ifa.arready, 1);

    // Sequential writes then readback
    for (int i = 0; i < 8; i++) write_and_check("seq_wr", 1'b0, 5'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 8; i++) read_and_check("seq_rd", 1'b0, 5'(i * 4));

    // Byte strobes
    write_and_check("strb_init", 1'b0, 5'h08, 32'h1122_3344, 4'hF);
    write_and_check("strb_wr",   1'b0, 5'h08, 32'hAABB_CCDD, 4'b0101);
    sel = 1'b0;
    axi_read(5'h08, d, r);
    check("strb_rd", d, 32'h11BB_33DD);
    check("strb_ctrl", ctrl_a[2*32 +: 32], 32'h11BB_33DD);

    // Read-only slot
    write_and_check("ro_wr", 1'b0, 5'h1C, 32'h1234_5678, 4'hF);
    sel = 1'b0;
    axi_read(5'h1C, d, r);
    check("ro_rd", d, 32'hCAFE_F00D);
    check("ro_rresp", r, 2'b00);

    // Unmapped indices on the 6-register bank
    sel = 1'b1;
    axi_read(5'h18, d, r);
    check("dec_rd_data", d, 0);
    check("dec_rd_resp", r, 2'b11);
    write_and_check("dec_wr", 1'b1, 5'h1C, 32'hFFFF_FFFF, 4'hF);
    write_and_check("b_wr5",  1'b1, 5'h14, 32'h5555_AAAA, 4'hF);
    read_and_check("b_rd5", 1'b1, 5'h14);
    sel = 1'b0;

    // W three cycles before AW, response held off for five cycles
    @(negedge clk);
    p0 = pulse_total;
    wdata = 32'h0BAD_BEEF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    check("ord_wready", m_wready, 1);
    @(negedge clk); wvalid = 1'b0;
    check("ord_w_held", m_wready, 0);
    check("ord_aw_open", m_awready, 1);
    repeat (2) @(negedge clk);
    awaddr = 5'h0C; awvalid = 1'b1;
    @(negedge clk); awvalid = 1'b0;
    check("ord_commit_wait", m_bvalid, 0);
    @(negedge clk);
    check("ord_bvalid", m_bvalid, 1);
    check("ord_bresp", m_bresp, 2'b00);
    begin
      logic [1:0] er; int ep;
      model_write(1'b0, 3, 32'h0BAD_BEEF, 4'hF, er, ep);
    end
    awaddr = 5'h10; wdata = 32'h600D_F00D; awvalid = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_bvalid", m_bvalid, 1);
      check("hold_awready", m_awready, 0);
      check("hold_wready", m_wready, 0);
    end
    check("hold_pulses", pulse_total - p0, 1);
    bready = 1'b1;
    @(negedge clk); bready = 1'b0;
    check("post_b_bvalid", m_bvalid, 0);
    check("post_b_awready", m_awready, 1);
    check("post_b_wready", m_wready, 1);
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
    check("second_wait", m_bvalid, 0);
    @(negedge clk);
    check("second_bvalid", m_bvalid, 1);
    check("second_bresp", m_bresp, 2'b00);
    bready = 1'b1;
    @(negedge clk); bready = 1'b0;
    begin
      logic [1:0] er; int ep;
      model_write(1'b0, 4, 32'h600D_F00D, 4'hF, er, ep);
    end
    read_and_check("ord_rd3", 1'b0, 5'h0C);
    read_and_check("ord_rd4", 1'b0, 5'h10);

    // Randomised traffic across both banks
    for (int t = 0; t < 40; t++) begin
      logic s;
      int idx;
      logic [4:0] a;
      s   = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 7);
      a   = 5'(idx * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        write_and_check("rnd_wr", s, a, $urandom, 4'($urandom_range(0, 15)));
      else
        read_and_check("rnd_rd", s, a);
    end
    sel = 1'b0;

    // Reset with both responses pending
    @(negedge clk);
    awaddr = 5'h04; wdata = 32'h7777_7777; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    araddr = 5'h08; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("mid_bvalid_pre", m_bvalid, 1);
    check("mid_rvalid_pre", m_rvalid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_bvalid_drop", m_bvalid, 0);
    check("mid_rvalid_drop", m_rvalid, 0);
    for (int i = 0; i < 7; i++) check("mid_reg_reset", ctrl_a[i*32 +: 32], RST_A);
    model_reset();
    @(negedge clk); rst = 1'b0; bready = 1'b1; rready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mid_no_stale_b", m_bvalid, 0);
      check("mid_no_stale_r", m_rvalid, 0);
    end
    bready = 1'b0; rready = 1'b0;
    read_and_check("mid_rd1", 1'b0, 5'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
